// File: rtl/if_stage_ctrl_pkg.sv
// Shared fetch-pipeline constants, state encodings and bundle types.
// Imported by the IF stage controller and its IF/ID holding buffer.
package if_stage_ctrl_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] PC_INC = 64'd4;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_word_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/if_stage_ctrl_if_id_buffer.sv
// One-entry holding register for a fetched word and its PC while
// decode is stalled.
module if_id_buffer
    import if_stage_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            Reset,
    input  logic            load,
    input  logic            clear,
    input  logic [ILEN-1:0] word_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            valid,
    output logic [ILEN-1:0] word,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            valid <= 1'b0;
            word  <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            word  <= word_in;
            pc    <= pc_in;
        end
    end

endmodule

// File: rtl/if_stage_ctrl.sv
// Instruction-fetch control: drives the PC register, the instruction
// memory request and the IF/ID pipeline register.
module if_stage_ctrl
    import if_stage_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            Reset,
    input  logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] NextPC,
    output logic            PCStall,
    input  logic            BranchTaken,
    input  logic [XLEN-1:0] BranchTarget,
    input  logic            IdStall,
    output logic            IMemReq,
    output logic [XLEN-1:0] IMemAddr,
    input  logic            IMemReady,
    input  logic [ILEN-1:0] IMemData,
    output logic            IfIdValid,
    output logic [ILEN-1:0] IfIdInstr,
    output logic [XLEN-1:0] IfIdPC
);

    logic [1:0]      state;
    logic [1:0]      state_nx;
    logic [XLEN-1:0] req_addr;
    fetch_word_t     ifid;
    logic            ifid_v;

    logic            in_fetch;
    logic            in_hold;
    logic            in_drain;
    logic            take_fetch;
    logic            take_hold;
    logic            park;

    logic            buf_v;
    logic [ILEN-1:0] buf_word;
    logic [XLEN-1:0] buf_pc;

    assign in_fetch = (state == ST_FETCH);
    assign in_hold  = (state == ST_HOLD);
    assign in_drain = (state == ST_DRAIN);

    assign take_fetch = in_fetch & IMemReady & ~BranchTaken & ~IdStall;
    assign park       = in_fetch & IMemReady & ~BranchTaken & IdStall;
    assign take_hold  = in_hold & buf_v & ~BranchTaken & ~IdStall;

    if_id_buffer u_buf (
        .clk     (clk),
        .Reset   (Reset),
        .load    (park),
        .clear   (BranchTaken | take_hold),
        .word_in (IMemData),
        .pc_in   (PC),
        .valid   (buf_v),
        .word    (buf_word),
        .pc      (buf_pc)
    );

    always_comb begin
        NextPC   = pc_next(PC);
        PCStall  = 1'b1;
        IMemReq  = 1'b0;
        IMemAddr = PC;
        state_nx = state;
        unique case (1'b1)
            in_fetch: begin
                IMemReq = 1'b1;
                PCStall = ~take_fetch;
                if (park)
                    state_nx = ST_HOLD;
            end
            in_hold: begin
                NextPC  = pc_next(buf_pc);
                PCStall = ~take_hold;
                if (take_hold)
                    state_nx = ST_FETCH;
            end
            in_drain: begin
                IMemReq  = 1'b1;
                IMemAddr = req_addr;
                NextPC   = PC;
                if (IMemReady)
                    state_nx = ST_FETCH;
            end
            default: state_nx = ST_FETCH;
        endcase
        // A redirect wins, but an unanswered request must still be drained.
        if (BranchTaken) begin
            NextPC  = BranchTarget;
            PCStall = 1'b0;
            if (in_fetch)
                state_nx = IMemReady ? ST_FETCH : ST_DRAIN;
            if (in_hold)
                state_nx = ST_FETCH;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state    <= ST_FETCH;
            req_addr <= '0;
        end else begin
            state <= state_nx;
            if (in_fetch)
                req_addr <= PC;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            ifid_v <= 1'b0;
            ifid   <= '0;
        end else if (BranchTaken) begin
            ifid_v <= 1'b0;
        end else if (take_fetch) begin
            ifid_v <= 1'b1;
            ifid   <= '{instr: IMemData, pc: PC};
        end else if (take_hold) begin
            ifid_v <= 1'b1;
            ifid   <= '{instr: buf_word, pc: buf_pc};
        end
    end

    assign IfIdValid = ifid_v;
    assign IfIdInstr = ifid.instr;
    assign IfIdPC    = ifid.pc;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Bench for if_stage_ctrl: directed scenarios plus randomized traffic
// against a queue-based fetch model that also owns the PC register.
module tb_if_stage_ctrl;

    logic        clk;
    logic        Reset;
    logic [63:0] PC;
    logic [63:0] NextPC;
    logic        PCStall;
    logic        BranchTaken;
    logic [63:0] BranchTarget;
    logic        IdStall;
    logic        IMemReq;
    logic [63:0] IMemAddr;
    logic        IMemReady;
    logic [31:0] IMemData;
    logic        IfIdValid;
    logic [31:0] IfIdInstr;
    logic [63:0] IfIdPC;

    if_stage_ctrl dut (
        .clk          (clk),
        .Reset        (Reset),
        .PC           (PC),
        .NextPC       (NextPC),
        .PCStall      (PCStall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .IdStall      (IdStall),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemReady    (IMemReady),
        .IMemData     (IMemData),
        .IfIdValid    (IfIdValid),
        .IfIdInstr    (IfIdInstr),
        .IfIdPC       (IfIdPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    // model: PC register, IF/ID contents, parked words, outstanding request
    logic [63:0] m_pc;
    logic        m_v;
    logic [31:0] m_instr;
    logic [63:0] m_ipc;
    logic [63:0] m_req_addr;
    logic        m_drain;
    logic [95:0] m_buf[$];

    logic        ovr_en;
    logic [31:0] ovr_word;

    logic [63:0] s_next;
    logic        s_stall;
    logic        s_req;
    logic [63:0] s_addr;

    function automatic logic [31:0] dat(input logic [63:0] a);
        if (ovr_en)
            return ovr_word;
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32];
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        ncmp++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic model_reset();
        m_pc       = '0;
        m_v        = 1'b0;
        m_instr    = '0;
        m_ipc      = '0;
        m_req_addr = '0;
        m_drain    = 1'b0;
        m_buf.delete();
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic rdy_i, input logic ids,
                        input logic br, input logic [63:0] tgt);
        logic        fetch_mode;
        logic        e_req;
        logic        e_stall;
        logic        rdy;
        logic [63:0] e_addr;
        logic [63:0] e_next;
        logic [31:0] d;
        fetch_mode = !m_drain && (m_buf.size() == 0);
        e_req  = m_drain || fetch_mode;
        e_addr = m_drain ? m_req_addr : m_pc;
        rdy    = rdy_i & e_req;
        d      = dat(e_addr);
        if (br) begin
            e_stall = 1'b0;
            e_next  = tgt;
        end else if (m_drain) begin
            e_stall = 1'b1;
            e_next  = '0;
        end else if (!fetch_mode) begin
            e_stall = ids;
            e_next  = m_buf[0][63:0] + 64'd4;
        end else begin
            e_stall = !(rdy && !ids);
            e_next  = m_pc + 64'd4;
        end
        PC           = m_pc;
        IMemReady    = rdy;
        IMemData     = d;
        IdStall      = ids;
        BranchTaken  = br;
        BranchTarget = tgt;
        #1;
        chk("ifid_valid", 64'(IfIdValid), 64'(m_v));
        if (m_v) begin
            chk("ifid_instr", 64'(IfIdInstr), 64'(m_instr));
            chk("ifid_pc", IfIdPC, m_ipc);
        end
        chk("imem_req", 64'(IMemReq), 64'(e_req));
        if (e_req)
            chk("imem_addr", IMemAddr, e_addr);
        chk("pc_stall", 64'(PCStall), 64'(e_stall));
        if (!e_stall)
            chk("next_pc", NextPC, e_next);
        s_next  = NextPC;
        s_stall = PCStall;
        s_req   = IMemReq;
        s_addr  = IMemAddr;
        if (fetch_mode)
            m_req_addr = m_pc;
        if (br) begin
            m_v = 1'b0;
            m_buf.delete();
            m_drain = m_drain ? !rdy : (fetch_mode && !rdy);
            m_pc = tgt;
        end else if (m_drain) begin
            if (rdy)
                m_drain = 1'b0;
        end else if (!fetch_mode) begin
            if (!ids) begin
                {m_instr, m_ipc} = m_buf.pop_front();
                m_v  = 1'b1;
                m_pc = m_ipc + 64'd4;
            end
        end else if (rdy) begin
            if (ids) begin
                m_buf.push_back({d, m_pc});
            end else begin
                m_instr = d;
                m_ipc   = m_pc;
                m_v     = 1'b1;
                m_pc    = m_pc + 64'd4;
            end
        end
        @(negedge clk);
    endtask

    // Called at a falling edge; reset is checked before any clock edge.
    task automatic do_reset();
        Reset       = 1'b1;
        BranchTaken = 1'b0;
        IMemReady   = 1'b0;
        IdStall     = 1'b0;
        PC          = '0;
        #1;
        chk("rst_valid", 64'(IfIdValid), 64'd0);
        chk("rst_instr", 64'(IfIdInstr), 64'd0);
        chk("rst_pc", IfIdPC, 64'd0);
        @(negedge clk);
        Reset = 1'b0;
        model_reset();
    endtask

    initial begin
        Reset        = 1'b1;
        PC           = '0;
        BranchTaken  = 1'b0;
        BranchTarget = '0;
        IdStall      = 1'b0;
        IMemReady    = 1'b0;
        IMemData     = '0;
        ovr_en       = 1'b0;
        ovr_word     = 32'hD503201F;
        model_reset();
        @(negedge clk);
        do_reset();

        // sequential fetch from 0
        step(1, 0, 0, '0);
        chk("seq_valid0", 64'(IfIdValid), 64'd1);
        chk("seq_pc0", IfIdPC, 64'h0);
        step(1, 0, 0, '0);
        chk("seq_pc1", IfIdPC, 64'h4);
        step(1, 0, 0, '0);
        chk("seq_pc2", IfIdPC, 64'h8);

        // memory wait states at 0x100
        step(1, 0, 1, 64'h100);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, '0);
            chk("wait_stall", 64'(s_stall), 64'd1);
            chk("wait_addr", s_addr, 64'h100);
        end
        step(1, 0, 0, '0);
        chk("wait_next", s_next, 64'h104);
        chk("wait_ifid_pc", IfIdPC, 64'h100);

        // decode stall parks the word
        ovr_en = 1'b1;
        step(1, 1, 0, '0);
        ovr_en = 1'b0;
        chk("park_stall", 64'(s_stall), 64'd1);
        step(0, 1, 0, '0);
        chk("hold_req", 64'(s_req), 64'd0);
        chk("hold_ifid_pc", IfIdPC, 64'h100);
        step(0, 0, 0, '0);
        chk("unpark_next", s_next, 64'h108);
        chk("unpark_instr", 64'(IfIdInstr), 64'hD503201F);
        chk("unpark_pc", IfIdPC, 64'h104);

        // redirect while a request is outstanding
        step(1, 0, 1, 64'h200);
        step(0, 0, 1, 64'h2000);
        chk("br_next", s_next, 64'h2000);
        chk("br_addr", s_addr, 64'h200);
        chk("br_valid", 64'(IfIdValid), 64'd0);
        step(0, 0, 0, '0);
        chk("drain_addr", s_addr, 64'h200);
        step(1, 0, 0, '0);
        chk("drop_valid", 64'(IfIdValid), 64'd0);
        step(1, 0, 0, '0);
        chk("tgt_addr", s_addr, 64'h2000);
        chk("tgt_ifid_pc", IfIdPC, 64'h2000);

        // redirect in HOLD with decode stalled, then PC wrap
        step(1, 1, 0, '0);
        step(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("holdbr_stall", 64'(s_stall), 64'd0);
        chk("holdbr_valid", 64'(IfIdValid), 64'd0);
        step(1, 0, 0, '0);
        chk("wrap_next", s_next, 64'h0);
        chk("wrap_ifid_pc", IfIdPC, 64'hFFFF_FFFF_FFFF_FFFC);

        // reset in the middle of a drain
        step(0, 0, 1, 64'h40);
        do_reset();
        step(0, 0, 0, '0);
        chk("post_rst_req", 64'(s_req), 64'd1);
        chk("post_rst_addr", s_addr, 64'h0);

        for (int i = 0; i < 3000; i++) begin
            logic [63:0] t;
            t = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 7) == 0)
                t = 64'hFFFF_FFFF_FFFF_FFF0 | (t & 64'hC);
            if (i % 750 == 749)
                do_reset();
            else
                step(1'($urandom_range(0, 2) != 0),
                     1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 9) == 0), t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/if_stage_ctrl.md
IF_STAGE_CTRL -- requirements
Module: if_stage_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 PC  input  64  current fetch address from the stallable PC register.
REQ-004 NextPC  output  64  D input of the PC register.
REQ-005 PCStall  output  1  Stall input of the PC register; 0 = PC loads NextPC at next edge.
REQ-006 BranchTaken  input  1  branch resolved taken downstream; redirect and flush this cycle.
REQ-007 BranchTarget  input  64  redirect address, valid when BranchTaken=1.
REQ-008 IdStall  input  1  decode stage cannot accept a new instruction.
REQ-009 IMemReq  output  1  instruction-memory request.
REQ-010 IMemAddr  output  64  request address; stable while IMemReq=1 and IMemReady=0.
REQ-011 IMemReady  input  1  memory returns IMemData this cycle; variable latency, min 0 wait cycles.
REQ-012 IMemData  input  32  fetched instruction word.
REQ-013 IfIdValid  output  1  IF/ID register holds a valid instruction.
REQ-014 IfIdInstr  output  32  IF/ID instruction.
REQ-015 IfIdPC  output  64  IF/ID instruction address.

Function
REQ-016 States: FETCH (request outstanding at PC), HOLD (fetched word buffered, decode stalled), DRAIN (discarding a stale outstanding request).
REQ-017 FETCH: IMemReq=1, IMemAddr=PC; ReqAddr register captures PC every FETCH cycle.
REQ-018 FETCH, IMemReady=0, BranchTaken=0: PCStall=1, IF/ID unchanged, stay FETCH.
REQ-019 FETCH, IMemReady=1, BranchTaken=0, IdStall=0: IfIdInstr<=IMemData, IfIdPC<=PC, IfIdValid<=1; NextPC=PC+4, PCStall=0; stay FETCH.
REQ-020 FETCH, IMemReady=1, BranchTaken=0, IdStall=1: word and PC into 1-entry buffer; IF/ID holds; PCStall=1; go HOLD.
REQ-021 HOLD: IMemReq=0; IdStall=0 and BranchTaken=0 -> buffer to IF/ID, IfIdValid<=1, NextPC=buffered PC+4, PCStall=0, go FETCH; otherwise PCStall=1.
REQ-022 BranchTaken=1 in any state: NextPC=BranchTarget, PCStall=0, IfIdValid<=0, buffer discarded; overrides IdStall and IMemReady data.
REQ-023 BranchTaken=1 in FETCH with IMemReady=1 or in HOLD: go FETCH; with IMemReady=0 in FETCH: go DRAIN.
REQ-024 DRAIN: IMemReq=1, IMemAddr=ReqAddr; PCStall=1 unless BranchTaken; IMemReady=1 -> data dropped, go FETCH.
REQ-025 BranchTaken=1 in DRAIN: NextPC=new target, PCStall=0, stay DRAIN until IMemReady.
REQ-026 PC arithmetic modulo 2^64; PC+4 from 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
REQ-027 Outputs NextPC, PCStall, IMemReq, IMemAddr combinational from state and inputs; IF/ID outputs registered.
REQ-028 Exactly one instruction enters IF/ID per accepted fetch; none duplicated or lost absent a branch.

Reset
REQ-029 Reset=1 asynchronously forces state FETCH, IfIdValid=0, IfIdInstr=0, IfIdPC=0, buffer empty, ReqAddr=0.
REQ-030 Reset mid-request abandons the request; the first post-reset fetch issues from the PC register value (0).

Structure
REQ-031 State encodings (FETCH, HOLD, DRAIN), instruction width 32, address width 64, and PC increment 4 belong in the shared pipeline package.
REQ-032 One sub-module is natural: if_id_buffer (1-entry word+PC holding register with load/clear).

Verification
REQ-033 Reset, PC=0, IMemReady=1 always, IdStall=0 -> IfIdPC 0,4,8 on consecutive cycles, IfIdValid=1 from the first edge.
REQ-034 PC=0x100, IMemReady low 3 cycles then high -> PCStall=1 for 3 cycles, IMemAddr=0x100 throughout, then IfIdPC=0x100, NextPC=0x104.
REQ-035 Word 0xD503201F returned with IdStall=1 for 2 cycles -> HOLD, IF/ID unchanged; IdStall drops -> IfIdInstr=0xD503201F, NextPC=PC+4.
REQ-036 BranchTaken=1, target 0x2000, while request to 0x200 outstanding -> NextPC=0x2000, IfIdValid=0, IMemAddr=0x200 until Ready, data dropped, next fetch at 0x2000.
REQ-037 BranchTaken=1 and IdStall=1 same cycle in HOLD -> IfIdValid=0, buffer cleared, PC loads target; PC=0xFFFF_FFFF_FFFF_FFFC fetch -> NextPC=0.
REQ-038 Reset asserted mid-DRAIN -> all registered outputs 0 immediately, state FETCH after release.
